// File: rtl/adder_pkg.sv
// Shared types and default sizes for the param_adder_pipe block.
// Optional build macro PARAM_ADDER_SAT_EN is consumed by param_adder_pipe.sv.
package adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } add_mode_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LAT     = 2;
  localparam int DEF_COUNT_W = 16;

endpackage

// File: rtl/param_adder_pipe_if.sv
// Operand/result handshake bundle for param_adder_pipe.
// master = driver side, slave = adder side.
interface param_adder_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic               clr;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               ovf_sticky;
  logic [COUNT_W-1:0] op_count;

  modport master (
    output in_valid, mode, a, b, cin, clr, out_ready,
    input  in_ready, out_valid, sum, cout, ovf_sticky, op_count
  );

  modport slave (
    input  in_valid, mode, a, b, cin, clr, out_ready,
    output in_ready, out_valid, sum, cout, ovf_sticky, op_count
  );
endinterface

// File: rtl/adder_pipe_stage.sv
// One pipeline register slice: loads d when en is high, clears on rst.
module adder_pipe_stage #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/param_adder_pipe.sv
// Pipelined adder with valid/ready flow control and an accumulate mode.
// Define PARAM_ADDER_SAT_EN to saturate the result on carry-out instead of wrapping.
module param_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LAT     = DEF_LAT,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input logic               clk,
  input logic               rst,
  param_adder_pipe_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  logic [STAGE_W-1:0] q_arr [1:LAT];
  stage_t             stage_in;
  stage_t             out_stage;

  logic [WIDTH-1:0]   acc_reg;
  logic               ovf_reg;
  logic [COUNT_W-1:0] count_reg;

  logic               advance;
  logic               accept;
  add_mode_e          mode;
  logic [WIDTH-1:0]   acc_eff;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH:0]     full;
  logic               carry;
  logic [WIDTH-1:0]   res_sum;

  assign out_stage = stage_t'(q_arr[LAT]);

  // The whole pipe moves together; only a held result at the tail blocks it.
  assign advance = !out_stage.valid || bus.out_ready;
  assign accept  = bus.in_valid && advance;
  assign mode    = add_mode_e'(bus.mode);

  // A clear in the same cycle as an ACC beat makes that beat start from zero.
  assign acc_eff = bus.clr ? '0 : acc_reg;
  assign operand = (mode == MODE_ACC) ? acc_eff : bus.b;
  assign full    = {1'b0, bus.a} + {1'b0, operand} + {{WIDTH{1'b0}}, bus.cin};
  assign carry   = full[WIDTH];

`ifdef PARAM_ADDER_SAT_EN
  assign res_sum = carry ? '1 : full[WIDTH-1:0];
`else
  assign res_sum = full[WIDTH-1:0];
`endif

  assign stage_in.valid = accept;
  assign stage_in.sum   = res_sum;
  assign stage_in.cout  = carry;

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    logic [STAGE_W-1:0] d;
    if (gi == 0) begin : g_first
      assign d = stage_in;
    end else begin : g_rest
      assign d = q_arr[gi];
    end
    adder_pipe_stage #(.W(STAGE_W)) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (advance),
      .d   (d),
      .q   (q_arr[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      if (accept && mode == MODE_ACC) begin
        acc_reg <= res_sum;
      end else if (bus.clr) begin
        acc_reg <= '0;
      end

      if (bus.clr) begin
        ovf_reg <= accept && carry;
      end else if (accept && carry) begin
        ovf_reg <= 1'b1;
      end

      if (accept && count_reg != '1) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign bus.in_ready   = advance;
  assign bus.out_valid  = out_stage.valid;
  assign bus.sum        = out_stage.sum;
  assign bus.cout       = out_stage.cout;
  assign bus.ovf_sticky = ovf_reg;
  assign bus.op_count   = count_reg;

endmodule
